// File: rtl/fir_decim_pkg.sv
// Shared constants and encodings for the FIR decimator slice.
package fir_decim_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ACC_W      = 48;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SHIFT_W    = 6;

    typedef enum logic {
        MODE_PICK = 1'b0,
        MODE_AVG  = 1'b1
    } mode_e;

endpackage

// File: rtl/fir_decimator_if.sv
// Sample stream in (valid only) and decimated stream out (valid/ready).
interface fir_decimator_if #(
    parameter int unsigned DATA_W = fir_decim_pkg::DATA_W
);

    logic [DATA_W-1:0] data_in;
    logic              data_in_valid;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic              data_out_ready;

    // Upstream source and downstream sink side
    modport master (
        output data_in,
        output data_in_valid,
        output data_out_ready,
        input  data_out,
        input  data_out_valid
    );

    // Decimator side
    modport slave (
        input  data_in,
        input  data_in_valid,
        input  data_out_ready,
        output data_out,
        output data_out_valid
    );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with flush; DEPTH must be a power of 2 (>= 2).
module sync_fifo_fwft #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; when full with a pop the write lands in the slot being vacated
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// Rate reducer for the FIR output: pick every R-th sample or average blocks of R,
// buffered in a small FWFT FIFO with a valid/ready output.
module fir_decimator #(
    parameter int unsigned DATA_W     = fir_decim_pkg::DATA_W,
    parameter int unsigned ACC_W      = fir_decim_pkg::ACC_W,
    parameter int unsigned CNT_W      = fir_decim_pkg::CNT_W,
    parameter int unsigned FIFO_DEPTH = fir_decim_pkg::FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             bypass,
    input  logic                             mode,
    input  logic [CNT_W-1:0]                 decim_factor,
    input  logic [fir_decim_pkg::SHIFT_W-1:0] avg_shift,
    output logic                             overflow,
    fir_decimator_if.slave                   bus
);

    import fir_decim_pkg::mode_e;
    import fir_decim_pkg::MODE_AVG;

    localparam int unsigned SW = fir_decim_pkg::SHIFT_W;

    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        r_q, r_d, r_in, r_cur;
    mode_e                   mode_q, mode_d, mode_in, mode_cur;
    logic [SW-1:0]           shift_q, shift_d, shift_cur;
    logic signed [ACC_W-1:0] acc_q, acc_d, sample_ext, acc_sum;
    logic                    push_q, push_d;
    logic [DATA_W-1:0]       push_data_q, push_data_d;
    logic                    overflow_q, overflow_d;
    logic                    accept, block_start, block_done;
    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]       fifo_rdata;

    // A factor of 0 behaves as 1
    assign r_in    = (decim_factor == '0) ? CNT_W'(1) : decim_factor;
    assign mode_in = mode_e'(mode);

    // Config for the current block: live inputs on the first sample, latched copy afterwards
    assign accept      = enable & bus.data_in_valid & ~bypass;
    assign block_start = (count_q == '0);
    assign r_cur       = block_start ? r_in      : r_q;
    assign mode_cur    = block_start ? mode_in   : mode_q;
    assign shift_cur   = block_start ? avg_shift : shift_q;
    assign block_done  = (count_q == (r_cur - CNT_W'(1)));
    assign sample_ext  = {{(ACC_W-DATA_W){bus.data_in[DATA_W-1]}}, bus.data_in};
    assign acc_sum     = acc_q + sample_ext;

    // FIFO handshake; bypass hides the FIFO and flushes it
    assign fifo_push = push_q & ~bypass;
    assign fifo_pop  = ~bypass & ~fifo_empty & bus.data_out_ready;

    // Block counter, accumulator, config latch and sticky overflow next-state
    always_comb begin
        count_d     = count_q;
        acc_d       = acc_q;
        r_d         = r_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        overflow_d  = overflow_q | (fifo_push & fifo_full & ~fifo_pop);

        if (bypass) begin
            count_d = '0;
            acc_d   = '0;
        end else if (accept) begin
            if (block_start) begin
                r_d     = r_in;
                mode_d  = mode_in;
                shift_d = avg_shift;
            end
            if (block_done) begin
                count_d     = '0;
                acc_d       = '0;
                push_d      = 1'b1;
                push_data_d = (mode_cur == MODE_AVG) ? DATA_W'(acc_sum >>> shift_cur)
                                                     : bus.data_in;
            end else begin
                count_d = count_q + CNT_W'(1);
                acc_d   = (mode_cur == MODE_AVG) ? acc_sum : '0;
            end
        end
    end

    // State registers; config is reloaded from the inputs during reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            acc_q       <= '0;
            r_q         <= r_in;
            mode_q      <= mode_in;
            shift_q     <= avg_shift;
            push_q      <= 1'b0;
            push_data_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            acc_q       <= acc_d;
            r_q         <= r_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bypass),
        .push      (fifo_push),
        .push_data (push_data_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Output mux: combinational pass-through in bypass, FIFO head otherwise
    assign bus.data_out       = bypass ? bus.data_in       : fifo_rdata;
    assign bus.data_out_valid = bypass ? bus.data_in_valid : ~fifo_empty;
    assign overflow           = overflow_q;

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the FIR low-pass filter; consumes its 32-bit filtered stream (data/valid, no back-pressure upstream).
- Reduces sample rate by a runtime factor R.
- Mode 0 picks every R-th sample; mode 1 averages each block of R samples (accumulate-and-dump).
- Decimated samples are buffered in a small FIFO and presented to the next stage with a valid/ready handshake.

Parameters:
- DATA_W, 32, input/output sample width (signed two's complement).
- ACC_W, 48, accumulator width for average mode.
- CNT_W, 16, width of decimation factor and block counter.
- FIFO_DEPTH, 4, output FIFO entries (power of 2).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, input samples are ignored; counter and accumulator hold; FIFO still drains.
- bypass  in  1  1: data_out=data_in, data_out_valid=data_in_valid (combinational); FIFO, counter and accumulator are flushed.
- mode  in  1  0 = pick, 1 = average.
- decim_factor  in  CNT_W  R; a value of 0 is treated as 1.
- avg_shift  in  6  right arithmetic shift applied to the accumulator in average mode.
- data_in  in  DATA_W  signed sample from the FIR.
- data_in_valid  in  1  one-cycle qualifier per sample.
- data_out  out  DATA_W  decimated sample (FIFO head).
- data_out_valid  out  1  FIFO non-empty (or data_in_valid in bypass).
- data_out_ready  in  1  downstream accepts when high with valid.
- overflow  out  1  sticky; a decimated sample was dropped because the FIFO was full.

Behaviour:
- Reset: count=0, acc=0, FIFO empty, data_out=0, data_out_valid=0, overflow=0. Latched R, mode and avg_shift are loaded from the inputs.
- Config latch: R, mode and avg_shift are sampled at reset and whenever count==0 and a sample is accepted. Changes mid-block take effect at the next block.
- Accept condition: enable & data_in_valid & !bypass.
- Counter:
  - count increments on each accepted sample.
  - When count==R_lat-1 the block completes: count<=0 and a push is generated.
  - R=1 pushes on every accepted sample.
- Pick mode: the pushed word is the sample accepted at count==R_lat-1 (the last of the block).
- Average mode:
  - acc accumulates sign-extended samples.
  - At block end the push word is ((acc + data_in) >>> avg_shift)[DATA_W-1:0], using a truncating arithmetic shift with no rounding or saturation.
  - acc is cleared to 0 in the same cycle.
- Push timing: the push occurs in the cycle after the block-completing sample is presented (registered). data_out_valid rises in the following cycle, so latency from input valid to output valid is 2 cycles when the FIFO is empty.
- FIFO:
  - First-word-fall-through; pop = data_out_valid & data_out_ready.
  - Push and pop in the same cycle are allowed, including when full (count unchanged).
  - Push when full and no pop: the word is dropped, overflow<=1 and holds until reset.
  - Pop when empty: no effect.
  - data_out holds the head value while not popped; it is stable when valid=1 and ready=0.
- Bypass:
  - Outputs are a combinational pass-through; data_out_ready is ignored.
  - Internal state is cleared each cycle bypass=1, except overflow, which is kept.
  - On bypass 1->0 the block restarts at count=0.
- Reset mid-block: the partial block is discarded and FIFO contents are lost.
- enable low mid-block: the partial block is retained and resumes when enable returns high.

Decomposition:
- Package fir_decim_pkg holds DATA_W, ACC_W, CNT_W, FIFO_DEPTH defaults, the mode encodings (MODE_PICK=0, MODE_AVG=1), and a localparam for the FIFO pointer width (clog2(FIFO_DEPTH)+1).
- Sub-module sync_fifo_fwft: parameterised depth/width, push/pop/full/empty, synchronous active-high reset.
- Decimator control (counter, accumulator, config latch, overflow) stays in fir_decimator.

Test Plan:
1. Pick: R=4, mode=0, inputs 1..12 valid every cycle, ready=1 -> outputs 4, 8, 12; each valid 2 cycles after samples 4/8/12.
2. Average: R=4, avg_shift=2, mode=1, inputs 10,20,30,40,-100,-100,-100,-104 -> outputs 25, then -101 (-404>>>2).
3. Back-pressure/overflow: R=1, ready=0, 6 samples -> FIFO holds the first 4, overflow=1 after the 5th. ready=1 then drains 1,2,3,4 in order with data stable while stalled.
4. Config change mid-block: R=3, then set R=2 after sample 2 -> first output is sample 3, then samples 5, 7.
5. Bypass/enable: bypass=1 -> data_out tracks data_in the same cycle. enable=0 for 3 cycles mid-block with R=4 -> the samples during the gap are ignored and the output is the 4th accepted sample.
6. R=0 and reset mid-block: R=0 behaves as R=1 (every sample out). Reset after 2 of 4 samples -> no output; the next block counts from 0.
